multiplier_seq_unsign: RTL and testbench

Sequential unsigned multiply-add unit computing p = a*b + c with a radix-2 shift-add datapath, one multiplier bit per cycle. It is the inverse of the unsigned divider: fed quotient, divisor and remainder, it reconstructs the dividend. It sits beside the divider in the arithmetic library for recomposition checks and for low-area multiply where latency is acceptable.

---
 rtl/multiplier_seq_unsign_if.sv | 15 +
 rtl/multiplier_seq_unsign.sv | 103 ++++++++++
 tb/tb_multiplier_seq_unsign.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/multiplier_seq_unsign_if.sv
// Request/result bundle for the sequential unsigned multiply-add unit.
interface multiplier_seq_unsign_if #(
   parameter int unsigned WIDTH = 32
);
   logic                 start;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic [WIDTH-1:0]     c;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   p;

   modport master (output start, a, b, c, input busy, done, p);
   modport slave  (input start, a, b, c, output busy, done, p);
endinterface

// File: rtl/multiplier_seq_unsign.sv
// Radix-2 shift-add unsigned multiply-add, p = a*b + c, one multiplier bit per cycle.
// Optional MULSEQ_EARLY_EXIT_EN stops once the remaining multiplier bits are all zero.
module multiplier_seq_unsign #(
   parameter int unsigned WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   multiplier_seq_unsign_if.slave  bus
);
   localparam int unsigned PW    = 2 * WIDTH;
   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [PW-1:0]     a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [PW-1:0]     acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PW-1:0]     p_q, p_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              accept_c;
   logic              last_c;
   logic [PW-1:0]     sum_c;

   assign accept_c = bus.start && (state_q != S_RUN);
   assign sum_c    = acc_q + (b_q[0] ? a_q : '0);

`ifdef MULSEQ_EARLY_EXIT_EN
   assign last_c = (cnt_q == CNT_W'(WIDTH - 1)) || ((b_q >> 1) == '0);
`else
   assign last_c = (cnt_q == CNT_W'(WIDTH - 1));
`endif

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.start) state_d = S_RUN;
         S_RUN:   if (last_c) state_d = S_DONE;
         S_DONE:  state_d = bus.start ? S_RUN : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath and output next values
   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      p_d    = p_q;
      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
      if (accept_c) begin
         a_d   = PW'(bus.a);
         b_d   = bus.b;
         acc_d = PW'(bus.c);
         cnt_d = '0;
      end else if (state_q == S_RUN) begin
         acc_d = sum_c;
         a_d   = a_q << 1;
         b_d   = b_q >> 1;
         cnt_d = cnt_q + CNT_W'(1);
         if (last_c) p_d = sum_c;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q    <= '0;
         b_q    <= '0;
         acc_q  <= '0;
         cnt_q  <= '0;
         p_q    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         acc_q  <= acc_d;
         cnt_q  <= cnt_d;
         p_q    <= p_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.p    = p_q;
endmodule

// File: tb/tb_multiplier_seq_unsign.sv
// Self-checking bench for multiplier_seq_unsign against an arithmetic reference model.
module tb_multiplier_seq_unsign;
   localparam int unsigned W = 32;
   localparam int TIMEOUT = 100;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   multiplier_seq_unsign_if #(.WIDTH(W)) bus ();

   multiplier_seq_unsign #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c);
      longint unsigned r;
      r = longint'(a) * longint'(b) + longint'(c);
      return 64'(r);
   endfunction

   function automatic int exp_lat(input logic [31:0] b);
`ifdef MULSEQ_EARLY_EXIT_EN
      int l;
      l = 1;
      for (int i = 0; i < 32; i++) if (b[i]) l = i + 1;
      return l;
`else
      return 32;
`endif
   endfunction

   // Issues one request; returns edges-to-done, result and busy seen in the done cycle.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         output int lat, output logic [63:0] pr, output logic busy_dn);
      @(negedge clk);
      bus.start = 1'b1;
      bus.a = a;
      bus.b = b;
      bus.c = c;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat = 0;
      while (lat < TIMEOUT) begin
         @(posedge clk);
         #1;
         lat++;
         if (bus.done === 1'b1) break;
      end
      pr = bus.p;
      busy_dn = bus.busy;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.start = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.c = '0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({bus.busy, bus.done, bus.p} !== 66'd0) begin
         n_fail++;
         $display("FAIL reset_state busy=%b done=%b p=%h required 0/0/0", bus.busy, bus.done, bus.p);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_recompose();
      int lat; logic [63:0] pr; logic bz;
      run_op(32'd17, 32'd13, 32'd12, lat, pr, bz);
      n_checks++;
      if (lat !== exp_lat(32'd13)) begin
         n_fail++; $display("FAIL recompose_latency got %0d required %0d", lat, exp_lat(32'd13));
      end
      n_checks++;
      if (pr !== 64'd233) begin
         n_fail++; $display("FAIL recompose_p got %0d required 233", pr);
      end
      n_checks++;
      if (bz !== 1'b0) begin
         n_fail++; $display("FAIL recompose_busy_in_done got %b required 0", bz);
      end
      @(posedge clk); #1;
      n_checks++;
      if (bus.done !== 1'b0 || bus.p !== 64'd233) begin
         n_fail++; $display("FAIL recompose_done_pulse done=%b p=%0d required 0/233", bus.done, bus.p);
      end
   endtask

   task automatic test_extremes();
      int lat; logic [63:0] pr; logic bz;
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, pr, bz);
      n_checks++;
      if (pr !== 64'hFFFF_FFFF_0000_0000) begin
         n_fail++; $display("FAIL extreme_max got %h required ffffffff00000000", pr);
      end
      run_op(32'd0, 32'd5, 32'd9, lat, pr, bz);
      n_checks++;
      if (pr !== 64'd9 || lat !== exp_lat(32'd5)) begin
         n_fail++; $display("FAIL extreme_a_zero p=%0d lat=%0d required 9/%0d", pr, lat, exp_lat(32'd5));
      end
      run_op(32'd123, 32'd0, 32'd77, lat, pr, bz);
      n_checks++;
      if (pr !== 64'd77 || lat !== exp_lat(32'd0)) begin
         n_fail++; $display("FAIL extreme_b_zero p=%0d lat=%0d required 77/%0d", pr, lat, exp_lat(32'd0));
      end
   endtask

   task automatic test_ignored_start();
      int lat; int extra;
      @(negedge clk);
      bus.start = 1'b1; bus.a = 32'd6; bus.b = 32'd7; bus.c = 32'd0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      bus.start = 1'b1; bus.a = 32'd100; bus.b = 32'd100; bus.c = 32'd3;
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat = 5;
      while (lat < TIMEOUT && bus.done !== 1'b1) begin
         @(posedge clk); #1; lat++;
      end
      n_checks++;
      if (bus.p !== 64'd42 || lat !== exp_lat(32'd7)) begin
         n_fail++; $display("FAIL ignored_start p=%0d lat=%0d required 42/%0d", bus.p, lat, exp_lat(32'd7));
      end
      extra = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
      end
      n_checks++;
      if (extra !== 0) begin
         n_fail++; $display("FAIL ignored_start_second_op got %0d active cycles required 0", extra);
      end
   endtask

   task automatic test_reset_mid_op();
      int seen;
      @(negedge clk);
      bus.start = 1'b1; bus.a = 32'd5; bus.b = 32'd7; bus.c = 32'd0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (9) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      n_checks++;
      if ({bus.busy, bus.done, bus.p} !== 66'd0) begin
         n_fail++; $display("FAIL reset_mid_op busy=%b done=%b p=%h required 0/0/0", bus.busy, bus.done, bus.p);
      end
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
      end
      n_checks++;
      if (seen !== 0) begin
         n_fail++; $display("FAIL reset_no_done got %0d active cycles required 0", seen);
      end
   endtask

   task automatic test_back_to_back();
      int lat; logic [63:0] pr; logic bz;
      run_op(32'd3, 32'd4, 32'd1, lat, pr, bz);
      n_checks++;
      if (pr !== 64'd13) begin
         n_fail++; $display("FAIL b2b_first got %0d required 13", pr);
      end
      bus.start = 1'b1; bus.a = 32'd2; bus.b = 32'd2; bus.c = 32'd0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.a = 32'd999; bus.b = 32'd999; bus.c = 32'd999;
      n_checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.p !== 64'd13) begin
         n_fail++; $display("FAIL b2b_restart busy=%b done=%b p=%0d required 1/0/13", bus.busy, bus.done, bus.p);
      end
      lat = 0;
      while (lat < TIMEOUT) begin
         @(posedge clk); #1; lat++;
         if (bus.done === 1'b1) break;
      end
      n_checks++;
      if (bus.p !== 64'd4 || lat !== exp_lat(32'd2)) begin
         n_fail++; $display("FAIL b2b_second p=%0d lat=%0d required 4/%0d", bus.p, lat, exp_lat(32'd2));
      end
   endtask

   task automatic test_divider_crosscheck();
      int lat; logic [63:0] pr; logic bz;
      int unsigned i, j;
      for (int k = 0; k < 24; k++) begin
         i = $urandom_range(255, 0);
         j = $urandom_range(255, 1);
         run_op(32'(i / j), 32'(j), 32'(i % j), lat, pr, bz);
         n_checks++;
         if (pr !== 64'(i) || lat !== exp_lat(32'(j))) begin
            n_fail++;
            $display("FAIL divider_recompose i=%0d j=%0d p=%0d lat=%0d required %0d/%0d",
                     i, j, pr, lat, i, exp_lat(32'(j)));
         end
      end
   endtask

   task automatic test_random();
      int lat; logic [63:0] pr; logic bz;
      logic [31:0] a, b, c;
      for (int k = 0; k < 24; k++) begin
         a = $urandom();
         b = (k % 4 == 0) ? 32'($urandom_range(15, 0)) : $urandom();
         c = $urandom();
         run_op(a, b, c, lat, pr, bz);
         n_checks++;
         if (pr !== model(a, b, c) || lat !== exp_lat(b) || bz !== 1'b0) begin
            n_fail++;
            $display("FAIL random_op a=%h b=%h c=%h p=%h lat=%0d busy=%b required %h/%0d/0",
                     a, b, c, pr, lat, bz, model(a, b, c), exp_lat(b));
         end
      end
   endtask

   task automatic test_early_exit();
      int lat; logic [63:0] pr; logic bz;
      run_op(32'd9, 32'd5, 32'd1, lat, pr, bz);
      n_checks++;
      if (pr !== 64'd46 || lat !== exp_lat(32'd5)) begin
         n_fail++; $display("FAIL latency_b5 p=%0d lat=%0d required 46/%0d", pr, lat, exp_lat(32'd5));
      end
      run_op(32'd11, 32'd0, 32'd7, lat, pr, bz);
      n_checks++;
      if (pr !== 64'd7 || lat !== exp_lat(32'd0)) begin
         n_fail++; $display("FAIL latency_b0 p=%0d lat=%0d required 7/%0d", pr, lat, exp_lat(32'd0));
      end
      run_op(32'd1, 32'h8000_0000, 32'd0, lat, pr, bz);
      n_checks++;
      if (pr !== 64'h8000_0000 || lat !== exp_lat(32'h8000_0000)) begin
         n_fail++; $display("FAIL latency_msb p=%h lat=%0d required 80000000/%0d", pr, lat, exp_lat(32'h8000_0000));
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      test_reset();
      test_recompose();
      test_extremes();
      test_ignored_start();
      test_reset_mid_op();
      test_back_to_back();
      test_divider_crosscheck();
      test_random();
      test_early_exit();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
